// File: rtl/desconcatenador_numeros_pkg.sv
// Shared definitions for the number de-concatenator (binary -> ASCII decimal TX feeder).
package desconcatenador_numeros_pkg;

   // One-hot sequencing states of the top-level FSM.
   typedef enum logic [5:0] {
      IDLE = 6'b000001,
      CONV = 6'b000010,
      SCAN = 6'b000100,
      SEND = 6'b001000,
      WAIT = 6'b010000,
      FIN  = 6'b100000
   } state_t;

   localparam logic [7:0] ASCII_ZERO        = 8'h30;
   localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h0A;

   // Decimal digits needed for 2**width - 1, i.e. ceil(width * log10(2)).
   // The 5-digit approximation of log10(2) is exact for any practical width.
   function automatic int unsigned digit_count(input int unsigned width);
      if (width == 0)
         return 1;
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/desconcatenador_numeros_bin2bcd_iter.sv
// Iterative double-dabble: one add-3/shift step per clock.
// The load cycle already performs the first step (the add-3 on a cleared
// BCD register is a no-op), so bcd_valid rises DATA_W cycles after load.
module bin2bcd_iter
   import desconcatenador_numeros_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NDIG   = digit_count(DATA_W)
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [DATA_W-1:0]   bin,
   output logic                busy,
   output logic                bcd_valid,
   output logic [4*NDIG-1:0]   bcd
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] bin_reg;
   logic [4*NDIG-1:0] bcd_reg;
   logic [4*NDIG-1:0] bcd_adj;
   logic [CNT_W-1:0]  cnt_reg;
   logic              valid_reg;

   // Per-digit add-3 correction; a nibble never exceeds 9 before the add,
   // so the 4-bit sum (max 12) cannot overflow.
   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     (bcd_reg[gi*4 +: 4] + 4'd3) :
                                      bcd_reg[gi*4 +: 4];
      end
   endgenerate

   // Shift engine: load does step 1, the remaining DATA_W-1 steps follow.
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_reg   <= '0;
         bcd_reg   <= '0;
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         {bcd_reg, bin_reg} <= {{(4*NDIG){1'b0}}, bin} << 1;
         cnt_reg            <= CNT_W'(DATA_W - 1);
         valid_reg          <= 1'b0;
      end else if (cnt_reg != '0) begin
         {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
         cnt_reg            <= cnt_reg - 1'b1;
         if (cnt_reg == CNT_W'(1))
            valid_reg <= 1'b1;
      end
   end

   assign busy      = (cnt_reg != '0);
   assign bcd_valid = valid_reg;
   assign bcd       = bcd_reg;

endmodule

// File: rtl/desconcatenador_numeros.sv
// Sends an unsigned value as ASCII decimal digits (MSD first) to a UART TX,
// one byte per start/done handshake, optionally followed by a terminator.
module desconcatenador_numeros
   import desconcatenador_numeros_pkg::*;
#(
   parameter int         DATA_W     = 32,
   parameter logic [7:0] ASCII_BASE = ASCII_ZERO,
   parameter bit         SEND_TERM  = 1'b1,
   parameter logic [7:0] TERM_CHAR  = TERM_CHAR_DEFAULT
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] valor,
   input  logic              start,
   output logic              busy,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_done,
   output logic              done
);

   localparam int NDIG  = digit_count(DATA_W);
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next, idx_dec, msd_idx;
   logic              term_reg, term_next;
   logic [7:0]        tx_data_reg, tx_data_next;
   logic              conv_load, conv_busy, conv_valid;
   logic [4*NDIG-1:0] bcd;
   logic [3:0]        digit [NDIG];

   bin2bcd_iter #(
      .DATA_W (DATA_W),
      .NDIG   (NDIG)
   ) u_bin2bcd (
      .clk       (clk),
      .reset     (reset),
      .load      (conv_load),
      .bin       (valor),
      .busy      (conv_busy),
      .bcd_valid (conv_valid),
      .bcd       (bcd)
   );

   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
         assign digit[gi] = bcd[gi*4 +: 4];
      end
   endgenerate

   assign idx_dec = idx_reg - 1'b1;

   // Most significant nonzero digit; an all-zero value leaves index 0 so "0" is sent.
   always_comb begin
      msd_idx = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (digit[i] != 4'd0)
            msd_idx = IDX_W'(i);
      end
   end

   // Next-state logic: sequencing, digit index walk and the byte to present.
   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      term_next    = term_reg;
      tx_data_next = tx_data_reg;
      conv_load    = 1'b0;
      unique case (state_reg)
         IDLE: begin
            term_next = 1'b0;
            if (start) begin
               conv_load  = 1'b1;
               state_next = CONV;
            end
         end
         CONV: begin
            if (conv_valid && !conv_busy)
               state_next = SCAN;
         end
         SCAN: begin
            idx_next     = msd_idx;
            tx_data_next = ASCII_BASE + {4'd0, digit[msd_idx]};
            state_next   = SEND;
         end
         SEND: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (tx_done) begin
               if (term_reg) begin
                  state_next = FIN;
               end else if (idx_reg == '0) begin
                  if (SEND_TERM) begin
                     term_next    = 1'b1;
                     tx_data_next = TERM_CHAR;
                     state_next   = SEND;
                  end else begin
                     state_next = FIN;
                  end
               end else begin
                  idx_next     = idx_dec;
                  tx_data_next = ASCII_BASE + {4'd0, digit[idx_dec]};
                  state_next   = SEND;
               end
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transfer in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         term_reg    <= 1'b0;
         tx_data_reg <= 8'h00;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         term_reg    <= term_next;
         tx_data_reg <= tx_data_next;
      end
   end

   // Moore outputs: pulses are exactly one state long.
   assign tx_start = (state_reg == SEND);
   assign done     = (state_reg == FIN);
   assign busy     = (state_reg != IDLE) && (state_reg != FIN);
   assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_desconcatenador_numeros.sv
// Bench for desconcatenador_numeros: one instance with terminator, one without.
module tb_desconcatenador_numeros;

   typedef struct {
      logic [31:0] valor;
      logic        sel;       // 0: terminator instance, 1: no terminator
      int          exp_n;     // bytes expected on the wire
      bit          disturb;   // re-pulse start and inject spurious tx_done
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        spur = 1'b0;
   logic        sel = 1'b0;
   logic        model_done = 1'b0;
   logic [31:0] valor = 32'd0;
   logic [1:0]  start_v, busy_v, tx_start_v, done_v, tx_done_v;
   logic [7:0]  tx_data_v [2];

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   nbytes = 0;
   int   ndone = 0;
   int   cnt = 0;
   int   first_tx_cyc = 0;
   int   last_tx_cyc = 0;
   int   last_done_cyc = 0;
   int   done_cyc = 0;
   logic busy_at_done = 1'b0;
   bit   spur_on_start = 1'b0;
   logic [7:0] exp_q [$];
   vec_t vecs [8];

   assign start_v   = {start & sel, start & ~sel};
   assign tx_done_v = {(model_done | spur) & sel, (model_done | spur) & ~sel};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         desconcatenador_numeros #(
            .DATA_W     (32),
            .ASCII_BASE (8'h30),
            .SEND_TERM  (gi == 0),
            .TERM_CHAR  (8'h0A)
         ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .valor    (valor),
            .start    (start_v[gi]),
            .busy     (busy_v[gi]),
            .tx_data  (tx_data_v[gi]),
            .tx_start (tx_start_v[gi]),
            .tx_done  (tx_done_v[gi]),
            .done     (done_v[gi])
         );
      end
   endgenerate

   always #5 clk = ~clk;

   // Cycle counter; cycle n is the period following the n-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference decimal expansion of v, pushed onto the scoreboard.
   task automatic push_expected(input logic [31:0] v, input bit term);
      logic [7:0] d [$];
      longint unsigned x;
      x = v;
      do begin
         d.push_front(8'h30 + 8'(x % 10));
         x = x / 10;
      end while (x != 0);
      foreach (d[i]) exp_q.push_back(d[i]);
      if (term) exp_q.push_back(8'h0A);
   endtask

   // TX model and output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      model_done = 1'b0;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            model_done    = 1'b1;
            last_done_cyc = cyc;
         end
      end
      if (tx_start_v[~sel])
         check("stray_tx_start", 32'(tx_start_v[~sel]), 32'd0);
      if (tx_start_v[sel]) begin
         nbytes++;
         if (nbytes == 1) first_tx_cyc = cyc;
         last_tx_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("extra_byte_qsize", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("tx_byte", 32'(tx_data_v[sel]), 32'(e));
            $display("byte %0d: tx_data=%02h expected=%02h cycle=%0d", nbytes, tx_data_v[sel], e, cyc);
         end
         cnt = 5;
         if (spur_on_start) model_done = 1'b1;
      end
      if (done_v[sel]) begin
         ndone++;
         done_cyc     = cyc;
         busy_at_done = busy_v[sel];
      end
   end

   task automatic run_txn(input logic [31:0] v, input logic s, input int exp_n, input bit disturb);
      int st;
      int waited;
      sel           = s;
      nbytes        = 0;
      ndone         = 0;
      spur_on_start = disturb;
      push_expected(v, (s == 1'b0));
      @(negedge clk);
      check("busy_before_start", 32'(busy_v[s]), 32'd0);
      valor = v;
      start = 1'b1;
      st    = cyc;
      @(negedge clk);
      start = 1'b0;
      valor = ~v;
      check("busy_after_start", 32'(busy_v[s]), 32'd1);
      waited = 0;
      while (ndone == 0 && waited < 600) begin
         @(negedge clk);
         waited++;
         start = 1'b0;
         spur  = 1'b0;
         if (disturb) begin
            if (cyc == st + 5)  spur  = 1'b1;
            if (cyc == st + 10) start = 1'b1;
            if (nbytes >= 1 && cyc == first_tx_cyc + 2) start = 1'b1;
         end
      end
      start = 1'b0;
      spur  = 1'b0;
      check("done_seen", 32'(ndone), 32'd1);
      repeat (4) @(negedge clk);
      spur_on_start = 1'b0;
      check("byte_count", 32'(nbytes), 32'(exp_n));
      check("done_pulses", 32'(ndone), 32'd1);
      check("first_tx_latency", 32'(first_tx_cyc - st), 32'd34);
      check("done_after_last_tx_done", 32'(done_cyc - last_done_cyc), 32'd1);
      check("busy_at_done", 32'(busy_at_done), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("txn valor=%0d sel=%0d disturb=%0d bytes=%0d done_pulses=%0d latency=%0d",
               v, s, disturb, nbytes, ndone, first_tx_cyc - st);
   endtask

   initial begin
      int waited;

      vecs[0] = '{valor: 32'd12345,      sel: 1'b0, exp_n: 6,  disturb: 1'b0};
      vecs[1] = '{valor: 32'd0,          sel: 1'b0, exp_n: 2,  disturb: 1'b0};
      vecs[2] = '{valor: 32'd4294967295, sel: 1'b0, exp_n: 11, disturb: 1'b0};
      vecs[3] = '{valor: 32'd1000,       sel: 1'b1, exp_n: 4,  disturb: 1'b0};
      vecs[4] = '{valor: 32'd12345,      sel: 1'b0, exp_n: 6,  disturb: 1'b1};
      vecs[5] = '{valor: 32'd10,         sel: 1'b1, exp_n: 2,  disturb: 1'b0};
      vecs[6] = '{valor: 32'd99999,      sel: 1'b1, exp_n: 5,  disturb: 1'b0};
      vecs[7] = '{valor: 32'd1000000000, sel: 1'b0, exp_n: 11, disturb: 1'b0};

      // Reset state of both instances.
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("reset_busy",     32'(busy_v[k]),     32'd0);
         check("reset_tx_start", 32'(tx_start_v[k]), 32'd0);
         check("reset_done",     32'(done_v[k]),     32'd0);
         check("reset_tx_data",  32'(tx_data_v[k]),  32'd0);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_txn(vecs[i].valor, vecs[i].sel, vecs[i].exp_n, vecs[i].disturb);

      // Abort in WAIT after two bytes of 98765.
      sel    = 1'b0;
      nbytes = 0;
      push_expected(32'd98765, 1'b1);
      @(negedge clk);
      valor = 32'd98765;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      waited = 0;
      while (!(nbytes == 2 && cyc == last_tx_cyc + 2) && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check("reset_point_reached", 32'(nbytes), 32'd2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy",     32'(busy_v[0]),     32'd0);
      check("abort_tx_start", 32'(tx_start_v[0]), 32'd0);
      check("abort_done",     32'(done_v[0]),     32'd0);
      check("abort_tx_data",  32'(tx_data_v[0]),  32'd0);
      exp_q.delete();
      repeat (12) @(negedge clk);
      check("abort_no_more_bytes", 32'(nbytes), 32'd2);
      $display("abort after %0d bytes of 98765", nbytes);
      run_txn(32'd7, 1'b0, 2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/desconcatenador_numeros.md
# desconcatenador_numeros

Transmit-side counterpart of the number concatenator. Accepts a 32-bit unsigned result, converts it to decimal with an iterative double-dabble, and feeds the digits most-significant first, as ASCII bytes, to the UART transmitter using a one-byte-at-a-time start/done handshake. An optional terminator byte follows the digits. The block sits between the ALU result path and the UART TX.

## Interface
Parameters:
- DATA_W, 32: width of the input value. The digit count is 10 for 32 bits.
- ASCII_BASE, 8'h30: added to each BCD digit to form the output byte.
- SEND_TERM, 1: 1 = append the TERM_CHAR byte after the last digit.
- TERM_CHAR, 8'h0A: terminator byte.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- valor, in, DATA_W: value to send, unsigned. Sampled on an accepted start.
- start, in, 1: request. Accepted only in IDLE; ignored while busy.
- busy, out, 1: high from the cycle after an accepted start until done.
- tx_data, out, 8: byte to transmit. Stable from tx_start until the matching tx_done.
- tx_start, out, 1: one-cycle pulse per byte.
- tx_done, in, 1: one-cycle pulse from the UART TX when the byte has finished.
- done, out, 1: one-cycle pulse after the final byte's tx_done.

## Operation
- Reset values: busy=0, tx_start=0, done=0, tx_data=8'h00, state=IDLE, internal BCD/shift registers cleared.
- Reset mid-operation aborts immediately. No tx_start may be issued on or after the reset cycle.
- FSM states and transitions:
  - IDLE: on start, latch valor, clear BCD, go to CONV.
  - CONV: runs DATA_W cycles. Each cycle: for every BCD nibble ≥5 add 3, then shift {bcd, bin} left by 1. Go to SCAN.
  - SCAN: finds the most significant nonzero digit index (1 cycle). A value of 0 yields index 0, so a single "0" is sent. Go to SEND.
  - SEND: drive tx_data = ASCII_BASE + digit[idx] (or TERM_CHAR in the terminator phase) and pulse tx_start. Go to WAIT.
  - WAIT: on tx_done, decrement idx and return to SEND.
    - After digit 0: go to SEND for the terminator if SEND_TERM, else to FIN.
    - After the terminator: go to FIN.
  - FIN: pulse done, drop busy, go to IDLE.
- Arithmetic: BCD register is 4×10 = 40 bits. Digit adds are 4-bit with no carry out; the pre-shift value is always ≤ 12.
- tx_done is sampled only in WAIT. Any tx_done in other states, including the tx_start cycle itself, is ignored.
- start arriving together with done (FIN cycle) is ignored. start is accepted again from the next IDLE cycle.
- valor changing after acceptance has no effect.

## Timing
- start sampled high at edge E (state IDLE):
  - busy=1 and CONV from E+1.
  - CONV occupies E+1..E+DATA_W.
  - SCAN at E+DATA_W+1.
  - First tx_start at E+DATA_W+2 (cycle E+34 for DATA_W=32).
- Each byte costs 1 SEND cycle + WAIT cycles until tx_done. The next tx_start is issued the cycle after tx_done.
- done is high for exactly one cycle, the cycle after the last tx_done. busy=0 in that same cycle.
- Byte count per value = digits (1..10) + SEND_TERM.

## Structure
- Shared package: FSM state encodings (IDLE, CONV, SCAN, SEND, WAIT, FIN, one-hot), ASCII_ZERO, default TERM_CHAR, and a function giving the digit count for a given DATA_W.
- One sub-module: bin2bcd_iter, the iterative double-dabble.
  - Ports: clk, reset, load, bin, busy, bcd_valid, bcd.
  - The top FSM keeps sequencing and the handshake.
- Top level: idx counter, terminator flag, tx_data mux, single-cycle pulse generation.

## Test plan
- valor=12345, SEND_TERM=1, TX model answers tx_done 5 cycles after each tx_start:
  - bytes 0x31,0x32,0x33,0x34,0x35,0x0A in order;
  - first tx_start 34 cycles after start;
  - one done pulse after the 6th tx_done.
- valor=0 → single byte 0x30 then 0x0A. valor=4294967295 → "4294967295" (10 bytes) then 0x0A.
- valor=1000, SEND_TERM=0 → 0x31,0x30,0x30,0x30 with inner zeros kept; done after the 4th tx_done.
- start re-pulsed during CONV and WAIT, plus spurious tx_done during CONV and in a tx_start cycle:
  - no extra bytes, no restart, sequence identical to the clean run.
- reset asserted in WAIT after 2 bytes of 98765:
  - next cycle busy=0, tx_start=0, done=0;
  - a fresh start with valor=7 sends 0x37,0x0A only.
